fm_sb_status: RTL

//  Return path of spy-buffer control: collects per-spy-buffer acknowledge/status
//  (freeze ack, memory-init done, playback busy) and packs it into 32-bit

---
 rtl/fm_sb_status.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fm_sb_status.sv
// fm_sb_status: spy-buffer control return path.
// Collects per-buffer freeze acknowledge, memory-init done and playback-busy
// flags. It packs them into 32-bit monitor words for the FM register block. It
// also tracks global freeze and spy-memory-initialize requests to completion
// or timeout.
//
// Ports
//   axi_clk, axi_reset          clock, synchronous active-high reset
//   freeze_req  [SB_N]          per-buffer freeze command (post-mask)
//   freeze_ack  [SB_N]          per-buffer frozen acknowledge
//   init_req                    initialize-spy-memory level
//   init_done   [SB_N]          per-buffer memory-cleared flag
//   pb_busy     [SB_N]          per-buffer playback-in-progress flag
//   freeze_status_0/_1          freeze_ack bits 31:0 / 63:32, unmapped bits 0
//   pb_status_0/_1              pb_busy packed the same way
//   freeze_done/freeze_timeout  freeze FSM in FROZEN / timed out
//   freeze_latency [LAT_W]      cycles spent freezing on last completion
//   init_busy/init_ok/init_err  init FSM state decode
module fm_sb_status #(
    parameter int unsigned SB_N        = 48,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned LAT_W       = 16
) (
    input  logic             axi_clk,
    input  logic             axi_reset,
    input  logic [SB_N-1:0]  freeze_req,
    input  logic [SB_N-1:0]  freeze_ack,
    input  logic             init_req,
    input  logic [SB_N-1:0]  init_done,
    input  logic [SB_N-1:0]  pb_busy,
    output logic [31:0]      freeze_status_0,
    output logic [31:0]      freeze_status_1,
    output logic [31:0]      pb_status_0,
    output logic [31:0]      pb_status_1,
    output logic             freeze_done,
    output logic             freeze_timeout,
    output logic [LAT_W-1:0] freeze_latency,
    output logic             init_busy,
    output logic             init_ok,
    output logic             init_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [63:0]      LAT_MAX  = (64'd1 << LAT_W) - 64'd1;

    typedef enum logic [1:0] {StFIdle, StFreezing, StFrozen, StFTmo} frz_state_e;
    typedef enum logic [1:0] {StIIdle, StIBusy, StIOk, StIErr} init_state_e;

    // Input stage
    logic [SB_N-1:0] freeze_req_q, freeze_ack_q, init_done_q, pb_busy_q;
    logic            init_req_q, init_req_d_q;
    // Set once init_req has been seen low after reset, so a level held high
    // through reset is not mistaken for a new request.
    logic            init_arm_q;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            freeze_req_q <= '0;
            freeze_ack_q <= '0;
            init_done_q  <= '0;
            pb_busy_q    <= '0;
            init_req_q   <= 1'b0;
            init_req_d_q <= 1'b0;
            init_arm_q   <= 1'b0;
        end else begin
            freeze_req_q <= freeze_req;
            freeze_ack_q <= freeze_ack;
            init_done_q  <= init_done;
            pb_busy_q    <= pb_busy;
            init_req_q   <= init_req;
            init_req_d_q <= init_req_q;
            init_arm_q   <= init_arm_q | ~init_req;
        end
    end

    // Status words; zero-extension keeps unmapped bits at 0
    logic [63:0] ack_ext, pb_ext;
    assign ack_ext = 64'(freeze_ack_q);
    assign pb_ext  = 64'(pb_busy_q);

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            freeze_status_0 <= '0;
            freeze_status_1 <= '0;
            pb_status_0     <= '0;
            pb_status_1     <= '0;
        end else begin
            freeze_status_0 <= ack_ext[31:0];
            freeze_status_1 <= ack_ext[63:32];
            pb_status_0     <= pb_ext[31:0];
            pb_status_1     <= pb_ext[63:32];
        end
    end

    // Freeze FSM
    frz_state_e       frz_state_q, frz_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d, lat_sat;
    logic             frz_any, unsat;

    assign frz_any = |freeze_req_q;
    assign unsat   = |(freeze_req_q & ~freeze_ack_q);

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            frz_state_q <= StFIdle;
            cnt_q       <= '0;
            lat_q       <= '0;
        end else begin
            frz_state_q <= frz_state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
        end
    end

    always_comb begin
        lat_sat     = (64'(cnt_q) > LAT_MAX) ? LAT_MAX[LAT_W-1:0] : LAT_W'(cnt_q);
        frz_state_d = frz_state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        unique case (frz_state_q)
            StFIdle: begin
                if (frz_any) begin
                    frz_state_d = StFreezing;
                    cnt_d       = '0;
                end
            end
            StFreezing: begin
                // Release beats completion, completion beats timeout
                if (!frz_any) begin
                    frz_state_d = StFIdle;
                end else if (!unsat) begin
                    frz_state_d = StFrozen;
                    lat_d       = lat_sat;
                end else if (cnt_q == CNT_LAST) begin
                    frz_state_d = StFTmo;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFrozen: begin
                if (!frz_any) begin
                    frz_state_d = StFIdle;
                end else if (unsat) begin
                    frz_state_d = StFreezing;
                    cnt_d       = '0;
                end
            end
            StFTmo: begin
                if (!frz_any) frz_state_d = StFIdle;
            end
            default: frz_state_d = StFIdle;
        endcase
    end

    always_comb begin
        freeze_done    = (frz_state_q == StFrozen);
        freeze_timeout = (frz_state_q == StFTmo);
        freeze_latency = lat_q;
    end

    // Init FSM
    init_state_e      init_state_q, init_state_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             init_rise;

    assign init_rise = init_req_q & ~init_req_d_q & init_arm_q;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            init_state_q <= StIIdle;
            icnt_q       <= '0;
        end else begin
            init_state_q <= init_state_d;
            icnt_q       <= icnt_d;
        end
    end

    always_comb begin
        init_state_d = init_state_q;
        icnt_d       = icnt_q;
        unique case (init_state_q)
            StIIdle, StIOk, StIErr: begin
                if (init_rise) begin
                    init_state_d = StIBusy;
                    icnt_d       = '0;
                end
            end
            StIBusy: begin
                // Further rises while busy do not restart the request
                if (&init_done_q) begin
                    init_state_d = StIOk;
                end else if (icnt_q == CNT_LAST) begin
                    init_state_d = StIErr;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            default: init_state_d = StIIdle;
        endcase
    end

    always_comb begin
        init_busy = (init_state_q == StIBusy);
        init_ok   = (init_state_q == StIOk);
        init_err  = (init_state_q == StIErr);
    end

endmodule
